// File: rtl/elevator_call_scheduler_if.sv
// Call-button inputs and car drive/door/status outputs of the elevator call scheduler.
// The master side drives requests; the slave side is the scheduler.
interface elevator_call_scheduler_if #(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = 2
);
  logic [N_FLOORS-1:0] req;
  logic                hold_door;
  logic [FLOOR_W-1:0]  floor;
  logic                dir;
  logic                moving;
  logic                door_open;
  logic [N_FLOORS-1:0] pending;
  logic                arrive;

  modport master (
    output req, hold_door,
    input  floor, dir, moving, door_open, pending, arrive
  );

  modport slave (
    input  req, hold_door,
    output floor, dir, moving, door_open, pending, arrive
  );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Collective (SCAN) elevator dispatcher: latches floor calls, moves the car one floor at a
// time, reverses only when no calls remain ahead, and times the door dwell.
//
// state | meaning
// IDLE  | car stopped, door closed; picks door, move ahead, or reverse-and-move
// MOVE  | travelling one floor; timer counts down the floor-to-floor time
// DOOR  | door open at current floor; timer counts down the dwell
module elevator_call_scheduler #(
  parameter int N_FLOORS    = 4,
  parameter int FLOOR_W     = 2,
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  elevator_call_scheduler_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  localparam int T_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_MOVE = TW'(MOVE_CYCLES);
  localparam logic [TW-1:0] T_DOOR = TW'(DOOR_CYCLES);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  logic [1:0]          state, state_n;
  logic [TW-1:0]       timer, timer_n;
  logic [FLOOR_W-1:0]  floor_r, floor_n, next_floor;
  logic                dir_r, dir_n;
  logic [N_FLOORS-1:0] pending_r, pending_n;
  logic                arrive_r, arrive_n;
  logic [N_FLOORS-1:0] eff, set_mask, clr_mask;

  // Any effective call strictly above f (d=0, UP) or strictly below f (d=1, DOWN).
  function automatic logic calls_beyond(input logic [N_FLOORS-1:0] e,
                                        input logic [FLOOR_W-1:0]  f,
                                        input logic                d);
    logic r;
    r = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (d ? (FLOOR_W'(i) < f) : (FLOOR_W'(i) > f))
        r = r | e[i];
    end
    return r;
  endfunction

  assign eff        = pending_r | bus.req;
  assign next_floor = dir_r ? (floor_r - FLOOR_W'(1)) : (floor_r + FLOOR_W'(1));

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    floor_n  = floor_r;
    dir_n    = dir_r;
    arrive_n = 1'b0;
    set_mask = bus.req;
    clr_mask = '0;

    case (state)
      IDLE: begin
        if (eff[floor_r]) begin
          state_n           = DOOR;
          timer_n           = T_DOOR;
          clr_mask[floor_r] = 1'b1;
        end else if (calls_beyond(eff, floor_r, dir_r)) begin
          state_n = MOVE;
          timer_n = T_MOVE;
        end else if (calls_beyond(eff, floor_r, ~dir_r)) begin
          state_n = MOVE;
          timer_n = T_MOVE;
          dir_n   = ~dir_r;
        end
      end

      MOVE: begin
        if (timer == T_ONE) begin
          floor_n  = next_floor;
          arrive_n = 1'b1;
          if (eff[next_floor]) begin
            state_n              = DOOR;
            timer_n              = T_DOOR;
            clr_mask[next_floor] = 1'b1;
          end else if (calls_beyond(eff, next_floor, dir_r)) begin
            timer_n = T_MOVE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - T_ONE;
        end
      end

      DOOR: begin
        // A call at the open floor is absorbed: it extends the dwell instead of latching.
        set_mask[floor_r] = 1'b0;
        if (bus.hold_door || bus.req[floor_r]) begin
          timer_n = T_DOOR;
        end else if (timer == T_ONE) begin
          state_n = IDLE;
        end else begin
          timer_n = timer - T_ONE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    pending_n = (pending_r | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      floor_r   <= '0;
      dir_r     <= 1'b0;
      pending_r <= '0;
      arrive_r  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      floor_r   <= floor_n;
      dir_r     <= dir_n;
      pending_r <= pending_n;
      arrive_r  <= arrive_n;
    end
  end

  assign bus.floor     = floor_r;
  assign bus.dir       = dir_r;
  assign bus.moving    = (state == MOVE);
  assign bus.door_open = (state == DOOR);
  assign bus.pending   = pending_r;
  assign bus.arrive    = arrive_r;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: expected arrive/door events are queued as
// stimulus is driven and compared (floor, leg/dwell length) as the car produces them.
module tb_elevator_call_scheduler;

  localparam logic [1:0] EV_ARR  = 2'd0;
  localparam logic [1:0] EV_DOOR = 2'd1;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] fl;
    logic [7:0] len;
  } ev_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  ev_t  exp_q[$];
  int   mv_cnt;
  int   door_cnt;
  int   ev_idx;

  elevator_call_scheduler_if bus ();

  elevator_call_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [1:0] f, input int n);
    ev_t e;
    e.kind = k;
    e.fl   = f;
    e.len  = 8'(n);
    exp_q.push_back(e);
  endtask

  task automatic log_event(input logic [1:0] k, input logic [1:0] f, input int n);
    ev_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = '1;
    chk($sformatf("sb%0d_kind", ev_idx), 32'(k), 32'(e.kind));
    chk($sformatf("sb%0d_floor", ev_idx), 32'(f), 32'(e.fl));
    chk($sformatf("sb%0d_len", ev_idx), 32'(n), 32'(e.len));
    ev_idx++;
  endtask

  function automatic logic cond(input int sel, input logic [1:0] fl);
    case (sel)
      0:       return bus.door_open;
      1:       return !bus.door_open;
      2:       return bus.arrive;
      default: return bus.door_open && (bus.floor == fl);
    endcase
  endfunction

  task automatic wait_until(input int sel, input logic [1:0] fl, input int budget,
                            input string tag);
    int   n;
    logic hit;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      hit = cond(sel, fl);
    end while (!hit && n < budget);
    chk({tag, "_timeout"}, 32'(hit), 32'd1);
  endtask

  // Event monitor: leg length at each arrive, dwell length at each door close.
  initial begin
    mv_cnt   = 0;
    door_cnt = 0;
    ev_idx   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mv_cnt   = 0;
        door_cnt = 0;
      end else begin
        if (bus.arrive) begin
          log_event(EV_ARR, bus.floor, mv_cnt);
          mv_cnt = bus.moving ? 1 : 0;
        end else if (bus.moving) begin
          mv_cnt++;
        end
        if (bus.door_open) begin
          door_cnt++;
        end else if (door_cnt != 0) begin
          log_event(EV_DOOR, bus.floor, door_cnt);
          door_cnt = 0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.hold_door = 1'b0;

    #2;
    chk("rst_floor",   32'(bus.floor),     32'd0);
    chk("rst_dir",     32'(bus.dir),       32'd0);
    chk("rst_moving",  32'(bus.moving),    32'd0);
    chk("rst_door",    32'(bus.door_open), 32'd0);
    chk("rst_pending", 32'(bus.pending),   32'd0);
    chk("rst_arrive",  32'(bus.arrive),    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset while travelling 1 -> 2
    @(negedge clk);
    bus.req = 4'b0100;
    push(EV_ARR, 2'd1, 8);
    @(negedge clk);
    bus.req = '0;
    wait_until(2, 2'd0, 20, "t1_arrive");
    chk("t1_floor1", 32'(bus.floor), 32'd1);
    repeat (3) @(negedge clk);
    chk("t1_moving_pre", 32'(bus.moving), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t1_floor",   32'(bus.floor),     32'd0);
    chk("t1_dir",     32'(bus.dir),       32'd0);
    chk("t1_pending", 32'(bus.pending),   32'd0);
    chk("t1_moving",  32'(bus.moving),    32'd0);
    chk("t1_door",    32'(bus.door_open), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: call at the idle floor opens the door on the same edge
    @(negedge clk);
    bus.req = 4'b0001;
    push(EV_DOOR, 2'd0, 16);
    @(negedge clk);
    bus.req = '0;
    chk("t2_door_open", 32'(bus.door_open), 32'd1);
    chk("t2_pending",   32'(bus.pending),   32'd0);
    wait_until(1, 2'd0, 30, "t2_close");
    chk("t2_moving", 32'(bus.moving), 32'd0);

    // 3: pulse for floor 3, passing 1 and 2
    bus.req = 4'b1000;
    push(EV_ARR, 2'd1, 8);
    push(EV_ARR, 2'd2, 8);
    push(EV_ARR, 2'd3, 8);
    push(EV_DOOR, 2'd3, 16);
    @(negedge clk);
    bus.req = '0;
    chk("t3_pending", 32'(bus.pending), 32'h8);
    chk("t3_moving",  32'(bus.moving),  32'd1);
    wait_until(3, 2'd3, 40, "t3_door");
    chk("t3_pending_clr", 32'(bus.pending), 32'd0);
    wait_until(1, 2'd0, 30, "t3_close");

    // 6: at top floor, calls at 2 and 0 force reversal
    bus.req = 4'b0101;
    push(EV_ARR, 2'd2, 8);
    push(EV_DOOR, 2'd2, 16);
    push(EV_ARR, 2'd1, 8);
    push(EV_ARR, 2'd0, 8);
    push(EV_DOOR, 2'd0, 16);
    @(negedge clk);
    bus.req = '0;
    chk("t6_dir",     32'(bus.dir),     32'd1);
    chk("t6_moving",  32'(bus.moving),  32'd1);
    chk("t6_pending", 32'(bus.pending), 32'h5);
    wait_until(3, 2'd2, 20, "t6_door2");
    chk("t6_pending2", 32'(bus.pending), 32'h1);
    wait_until(1, 2'd0, 30, "t6_close2");
    wait_until(3, 2'd0, 40, "t6_door0");
    chk("t6_pending0", 32'(bus.pending), 32'd0);
    wait_until(1, 2'd0, 30, "t6_close0");

    // 4: heading to 3, pick up 1 on the way, 0 is served after reversal
    bus.req = 4'b1000;
    push(EV_ARR, 2'd1, 8);
    push(EV_DOOR, 2'd1, 16);
    push(EV_ARR, 2'd2, 8);
    push(EV_ARR, 2'd3, 8);
    push(EV_DOOR, 2'd3, 16);
    push(EV_ARR, 2'd2, 8);
    push(EV_ARR, 2'd1, 8);
    push(EV_ARR, 2'd0, 8);
    push(EV_DOOR, 2'd0, 16);
    @(negedge clk);
    bus.req = '0;
    chk("t4_dir_up", 32'(bus.dir), 32'd0);
    repeat (2) @(negedge clk);
    bus.req = 4'b0010;
    @(negedge clk);
    bus.req = '0;
    chk("t4_pending_a", 32'(bus.pending), 32'ha);
    wait_until(3, 2'd1, 20, "t4_door1");
    chk("t4_pending_b", 32'(bus.pending), 32'h8);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    chk("t4_pending_c", 32'(bus.pending),   32'h9);
    chk("t4_door_held", 32'(bus.door_open), 32'd1);
    wait_until(3, 2'd0, 150, "t4_door0");
    chk("t4_dir_down",  32'(bus.dir),     32'd1);
    chk("t4_pending_d", 32'(bus.pending), 32'd0);
    wait_until(1, 2'd0, 30, "t4_close0");

    // 5: hold_door for 10 cycles extends the dwell at floor 2
    bus.req = 4'b0100;
    push(EV_ARR, 2'd1, 8);
    push(EV_ARR, 2'd2, 8);
    push(EV_DOOR, 2'd2, 26);
    @(negedge clk);
    bus.req = '0;
    wait_until(0, 2'd0, 30, "t5_door");
    chk("t5_floor", 32'(bus.floor), 32'd2);
    bus.hold_door = 1'b1;
    repeat (10) @(negedge clk);
    bus.hold_door = 1'b0;
    wait_until(1, 2'd0, 30, "t5_close");
    chk("t5_dir", 32'(bus.dir), 32'd0);

    // Call at the open floor is absorbed and restarts the dwell
    bus.req = 4'b0100;
    push(EV_DOOR, 2'd2, 21);
    @(negedge clk);
    bus.req = '0;
    repeat (4) @(negedge clk);
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = '0;
    chk("ab_pending", 32'(bus.pending), 32'd0);
    wait_until(1, 2'd0, 30, "ab_close");

    repeat (2) @(negedge clk);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
